// File: rtl/alu_arbiter.sv
// Two-requester front end that shares one OTTER-encoded 32-bit ALU.
// Each operation takes 3 states: IDLE (grant/accept), EXEC (evaluate), RESP (hold result).
module alu_arbiter_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  func,
  output logic [31:0] y
);
  always_comb begin
    y = a + b;
    case (func)
      4'b0000: y = a + b;
      4'b1000: y = a - b;
      4'b0110: y = a | b;
      4'b0111: y = a & b;
      4'b0100: y = a ^ b;
      4'b0101: y = a >> b[4:0];
      4'b0001: y = a << b[4:0];
      4'b1101: y = $unsigned($signed(a) >>> b[4:0]);
      4'b0010: y = {31'b0, $signed(a) < $signed(b)};
      4'b0011: y = {31'b0, a < b};
      4'b1001: y = a;
      default: y = a + b;
    endcase
  end
endmodule

module alu_arbiter (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_srcA,
  input  logic [31:0] req0_srcB,
  input  logic [3:0]  req0_func,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_srcA,
  input  logic [31:0] req1_srcB,
  input  logic [3:0]  req1_func,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  input  logic        rsp1_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, gnt_q, gnt_d, accept, done;
  logic [31:0] a_q, b_q, res_q, alu_y;
  logic [3:0]  f_q;

  // Tie goes to the pointer; otherwise whichever side is valid (req1 only if req0 idle).
  assign gnt_d  = (req0_valid & req1_valid) ? prio_q : req1_valid;
  // RST_N gating keeps ready low while reset is held, even though state already reads IDLE.
  assign accept = RST_N & (state_q == IDLE) & (req0_valid | req1_valid);
  assign done   = (state_q == RESP) & (gnt_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  alu_arbiter_alu u_alu (.a(a_q), .b(b_q), .func(f_q), .y(alu_y));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q <= gnt_d;
        a_q   <= gnt_d ? req1_srcA : req0_srcA;
        b_q   <= gnt_d ? req1_srcB : req0_srcB;
        f_q   <= gnt_d ? req1_func : req0_func;
      end
      if (state_q == EXEC) res_q <= alu_y;
      if (done) prio_q <= ~gnt_q;
    end
  end

  assign req0_ready  = accept & ~gnt_d;
  assign req1_ready  = accept &  gnt_d;
  assign rsp0_valid  = (state_q == RESP) & ~gnt_q;
  assign rsp1_valid  = (state_q == RESP) &  gnt_q;
  assign rsp0_result = gnt_q ? 32'd0 : res_q;
  assign rsp1_result = gnt_q ? res_q : 32'd0;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant/priority, latency, stalls, ALU ops, reset abort.
module tb_alu_arbiter;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        req0_valid = 0, req0_ready, rsp0_valid, rsp0_ready = 0;
  logic        req1_valid = 0, req1_ready, rsp1_valid, rsp1_ready = 0;
  logic [31:0] req0_srcA = 0, req0_srcB = 0, req1_srcA = 0, req1_srcB = 0;
  logic [3:0]  req0_func = 0, req1_func = 0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        busy;
  int          checks = 0, fails = 0;

  localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b1000, F_OR = 4'b0110, F_AND = 4'b0111,
    F_XOR = 4'b0100, F_SRL = 4'b0101, F_SLL = 4'b0001, F_SRA = 4'b1101, F_SLT = 4'b0010,
    F_SLTU = 4'b0011, F_CPY = 4'b1001;

  alu_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srcA(req0_srcA),
    .req0_srcB(req0_srcB), .req0_func(req0_func), .rsp0_valid(rsp0_valid),
    .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srcA(req1_srcA),
    .req1_srcB(req1_srcB), .req1_func(req1_func), .rsp1_valid(rsp1_valid),
    .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic v, input logic [31:0] a, b, input logic [3:0] f);
    if (who == 0) begin req0_valid = v; req0_srcA = a; req0_srcB = b; req0_func = f; end
    else          begin req1_valid = v; req1_srcA = a; req1_srcB = b; req1_func = f; end
  endtask

  // One operation from a single requester, with `stall` extra RESP cycles before rsp_ready.
  task automatic run_one(input int who, input logic [31:0] a, b, input logic [3:0] f,
                         input logic [31:0] exp, input int stall);
    @(negedge CLK);
    drive(who, 1'b1, a, b, f);
    #1;
    chk("ready_at_accept", who ? req1_ready : req0_ready, 1);
    chk("other_ready_low", who ? req0_ready : req1_ready, 0);
    @(negedge CLK);
    drive(who, 1'b0, 32'hDEADBEEF, 32'h0000001F, 4'b0111);
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_no_rsp", {31'b0, rsp0_valid | rsp1_valid}, 0);
    @(negedge CLK);
    for (int i = 0; i <= stall; i++) begin
      chk("rsp_valid", who ? rsp1_valid : rsp0_valid, 1);
      chk("rsp_result", who ? rsp1_result : rsp0_result, exp);
      chk("other_valid_low", who ? rsp0_valid : rsp1_valid, 0);
      chk("other_result_zero", who ? rsp0_result : rsp1_result, 0);
      chk("resp_busy", busy, 1);
      if (i == stall) begin
        if (who == 0) rsp0_ready = 1; else rsp1_ready = 1;
      end
      @(negedge CLK);
    end
    rsp0_ready = 0; rsp1_ready = 0;
    chk("idle_busy", busy, 0);
    chk("idle_no_rsp", {31'b0, rsp0_valid | rsp1_valid}, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0;
    #1;
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
  endtask

  typedef struct { int who; logic [31:0] a, b; logic [3:0] f; logic [31:0] exp; } vec_t;
  vec_t vecs[$];

  initial begin
    // Reset state, including ready held low with valids high.
    req0_valid = 1; req1_valid = 1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_result0", rsp0_result, 0);
    chk("rst_result1", rsp1_result, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge CLK); RST_N = 1;

    // req0 alone: 5+7
    run_one(0, 32'd5, 32'd7, F_ADD, 32'd12, 0);
    // pointer now at req1: a tie must grant req1
    @(negedge CLK);
    req0_valid = 1; req1_valid = 1; #1;
    chk("tie_after_r0_ready1", req1_ready, 1);
    chk("tie_after_r0_ready0", req0_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // Both valid right after reset: req0 first, then req1, then tie back to req0.
    do_reset();
    drive(0, 1, 32'd3, 32'd5, F_SUB);
    drive(1, 1, 32'h000000FF, 32'h0000000F, F_XOR);
    #1;
    chk("both_ready0", req0_ready, 1);
    chk("both_ready1", req1_ready, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, F_ADD);
    chk("exec_ready1_low", req1_ready, 0);
    @(negedge CLK);
    chk("both_rsp0_valid", rsp0_valid, 1);
    chk("both_rsp0_result", rsp0_result, 32'hFFFFFFFE);
    chk("both_rsp1_low", rsp1_valid, 0);
    chk("resp_ready1_low", req1_ready, 0);
    rsp0_ready = 1;
    @(negedge CLK);
    rsp0_ready = 0;
    chk("second_ready1", req1_ready, 1);
    chk("second_rsp0_low", rsp0_valid, 0);
    @(negedge CLK);
    drive(1, 0, 0, 0, F_ADD);
    @(negedge CLK);
    chk("both_rsp1_valid", rsp1_valid, 1);
    chk("both_rsp1_result", rsp1_result, 32'h000000F0);
    chk("both_rsp0_result0", rsp0_result, 0);
    rsp1_ready = 1;
    @(negedge CLK);
    rsp1_ready = 0;
    req0_valid = 1; req1_valid = 1; #1;
    chk("tie_after_r1_ready0", req0_ready, 1);
    chk("tie_after_r1_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // Stalled response held stable
    run_one(1, 32'h80000000, 32'd4, F_SRA, 32'hF8000000, 3);

    vecs.push_back('{0, 32'hFFFFFFFF, 32'd1, F_SLT, 32'd1});
    vecs.push_back('{1, 32'hFFFFFFFF, 32'd1, F_SLTU, 32'd0});
    vecs.push_back('{0, 32'd2, 32'd3, 4'b1111, 32'd5});
    vecs.push_back('{1, 32'd0, 32'd1, F_SUB, 32'hFFFFFFFF});
    vecs.push_back('{0, 32'h80000001, 32'h00000021, F_SLL, 32'h00000002});
    vecs.push_back('{1, 32'h80000000, 32'd31, F_SRL, 32'h00000001});
    vecs.push_back('{0, 32'hF0F0F0F0, 32'h0F0F00FF, F_OR, 32'hFFFFF0FF});
    vecs.push_back('{1, 32'hF0F0F0F0, 32'h0FF000FF, F_AND, 32'h00F000F0});
    vecs.push_back('{0, 32'h12345678, 32'hAAAAAAAA, F_CPY, 32'h12345678});
    vecs.push_back('{1, 32'hFFFFFFFF, 32'd2, F_ADD, 32'h00000001});
    vecs.push_back('{0, 32'd1, 32'hFFFFFFFF, F_SLT, 32'd0});
    foreach (vecs[i]) run_one(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp, 0);

    // Reset during EXEC discards the operation; pointer returns to req0.
    @(negedge CLK);
    drive(1, 1, 32'd9, 32'd9, F_ADD);
    @(negedge CLK);
    drive(1, 0, 0, 0, F_ADD);
    chk("abort_exec_busy", busy, 1);
    RST_N = 0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("abort_result1", rsp1_result, 0);
    @(negedge CLK);
    RST_N = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_abort_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 0);
      chk("post_abort_idle", busy, 0);
    end
    req0_valid = 1; req1_valid = 1; #1;
    chk("post_abort_tie0", req0_ready, 1);
    chk("post_abort_tie1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    run_one(1, 32'd10, 32'd20, F_ADD, 32'd30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and the function code at 4 bits (OTTER alu_func encoding).
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 presents an operation.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle when req0_valid=1.
REQ-006 req0_srcA, req0_srcB  in  32 each  requester 0 operands.
REQ-007 req0_func  in  4  requester 0 ALU function code.
REQ-008 rsp0_valid  out  1  result for requester 0 is available.
REQ-009 rsp0_result  out  32  result for requester 0.
REQ-010 rsp0_ready  in  1  requester 0 consumes the result.
REQ-011 req1_valid, req1_ready, req1_srcA, req1_srcB, req1_func, rsp1_valid, rsp1_result, rsp1_ready have the same directions, widths and meanings for requester 1.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The block shall contain exactly one ALU instance and share it between the two requesters, one operation at a time.
REQ-014 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on acceptance, EXEC->RESP unconditionally, RESP->IDLE when rspN_valid & rspN_ready for the granted N.
REQ-015 Grant in IDLE: if only one reqN_valid is high, grant N; if both are high, grant the requester indicated by a 1-bit priority pointer.
REQ-016 reqN_ready shall be high only in IDLE and only for the granted N, and may combinationally depend on both valid inputs; it shall be low in EXEC and RESP.
REQ-017 On acceptance, srcA, srcB, func and grant index shall be latched; later changes on request inputs shall not affect the operation.
REQ-018 In EXEC the ALU shall evaluate the latched operands and the result shall be registered at the end of EXEC.
REQ-019 Latency: acceptance edge at cycle N; rspN_valid high from cycle N+2.
REQ-020 In RESP only the granted rspN_valid shall be high; the result shall stay stable until the handshake completes, however long rspN_ready stays low.
REQ-021 The non-granted rsp_valid shall remain low at all times.
REQ-022 rspN_result shall equal the registered result; the non-granted result output shall be 0.
REQ-023 On RESP completion, the priority pointer shall point to the requester not just served.
REQ-024 ALU semantics: 0000 add, 1000 sub, 0110 or, 0111 and, 0100 xor, 0101 srl, 0001 sll, 1101 sra, 0010 slt signed, 0011 sltu, 1001 copy srcA. Any other code shall add. Shifts use srcB[4:0]. Arithmetic wraps modulo 2^32.
REQ-025 Back-to-back: the next acceptance may occur no earlier than the cycle after RESP completes (IDLE), giving a throughput of one operation per 3 cycles minimum.

Reset
REQ-026 While RST_N=0 (asynchronously): state=IDLE, priority pointer=requester 0, rsp0_valid=rsp1_valid=0, results=0, busy=0, and req0_ready=req1_ready=0.
REQ-027 Reset asserted mid-EXEC or mid-RESP shall discard the in-flight operation; no response for it shall be produced after reset release.
REQ-028 The first grant after reset release shall follow REQ-015 with the pointer at requester 0.

Verification
REQ-029 req0 only: add 5+7 -> req0_ready=1 at acceptance; rsp0_valid=1 with rsp0_result=12 two cycles later; rsp1_valid stays 0.
REQ-030 Both valid after reset: req0 sub 3-5, req1 xor 0xFF^0x0F -> req0 served first with 0xFFFFFFFE, then req1 with 0x000000F0; next tie is granted to req0.
REQ-031 req1 sra 0x80000000 by 4 with rsp1_ready low for 3 cycles -> rsp1_result=0xF8000000, stable and valid throughout; busy stays high until the handshake completes.
REQ-032 slt -1 vs 1 -> 1; sltu 0xFFFFFFFF vs 1 -> 0; func 4'b1111 on 2,3 -> 5.
REQ-033 RST_N pulsed low during EXEC -> all outputs reset immediately; after release no rsp_valid is asserted until a new request is accepted.
